// File: rtl/cntr_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// cntr_snapshot_fifo
// Captures snapshots of three counter buses into a small first-word-fall-through
// FIFO, either on request or automatically whenever counter 2 wraps. Also checks
// that counter 2 advances by exactly one per clock and counts its wraps.
//
// Ports:
//   CLK        rising-edge clock
//   RST_B      asynchronous active-low reset
//   CLR        synchronous clear of FIFO, sticky flags, wrap count and history
//   SNAP_REQ   capture request
//   CNTR_IN1/2/3  counter values (counter 2 is checked and is the wrap source)
//   SNAP_DATA  head entry {CNTR_IN3, CNTR_IN2, CNTR_IN1}, zero when empty
//   SNAP_VALID FIFO non-empty
//   SNAP_READY consumer accepts the head entry
//   FILL       current entry count 0..DEPTH
//   OVERFLOW   sticky: a capture was dropped because the FIFO was full
//   STEP_ERR   sticky: counter 2 did not advance by exactly one
//   WRAP_CNT   number of counter 2 wraps, saturating at 255
// -----------------------------------------------------------------------------
module cntr_snapshot_fifo #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                 CLK,
    input  logic                 RST_B,
    input  logic                 CLR,
    input  logic                 SNAP_REQ,
    input  logic [WIDTH-1:0]     CNTR_IN1,
    input  logic [WIDTH-1:0]     CNTR_IN2,
    input  logic [WIDTH-1:0]     CNTR_IN3,
    output logic [3*WIDTH-1:0]   SNAP_DATA,
    output logic                 SNAP_VALID,
    input  logic                 SNAP_READY,
    output logic [ADDR_W:0]      FILL,
    output logic                 OVERFLOW,
    output logic                 STEP_ERR,
    output logic [7:0]           WRAP_CNT
);

    localparam int              EW      = 3 * WIDTH;
    localparam logic [ADDR_W:0] FULL_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_F_C = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_P_C = ADDR_W'(1);
    localparam logic [WIDTH-1:0]  ONE_W_C = WIDTH'(1);

    // Storage and state
    logic [EW-1:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_fill;
    logic [EW-1:0]     r_data;
    logic              r_valid;
    logic              r_ovf;
    logic              r_step_err;
    logic [7:0]        r_wrap_cnt;
    logic [WIDTH-1:0]  r_prev2;
    logic              r_prev_valid;

    // Combinational decode
    logic [EW-1:0]     w_entry;
    logic              w_wrap;
    logic              w_capture;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_step_bad;
    logic [ADDR_W:0]   w_fill_nxt;
    logic [ADDR_W:0]   w_remain;
    logic [ADDR_W-1:0] w_rptr_nxt;
    logic [ADDR_W-1:0] w_wptr_nxt;
    logic [EW-1:0]     w_data_nxt;

    assign w_entry    = {CNTR_IN3, CNTR_IN2, CNTR_IN1};
    assign w_wrap     = r_prev_valid && (r_prev2 == {WIDTH{1'b1}}) && (CNTR_IN2 == {WIDTH{1'b0}});
    assign w_capture  = SNAP_REQ || w_wrap;
    assign w_pop      = r_valid && SNAP_READY;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign w_push     = w_capture && ((r_fill != FULL_C) || w_pop);
    assign w_drop     = w_capture && !w_push;
    assign w_step_bad = r_prev_valid && (CNTR_IN2 != (r_prev2 + ONE_W_C));

    // Next pointer/fill values and the head entry to present after this edge
    always_comb begin
        w_fill_nxt = r_fill;
        w_rptr_nxt = r_rptr;
        w_wptr_nxt = r_wptr;
        w_remain   = r_fill;
        w_data_nxt = {EW{1'b0}};

        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + ONE_F_C;
        end else if (!w_push && w_pop) begin
            w_fill_nxt = r_fill - ONE_F_C;
        end else begin
            w_fill_nxt = r_fill;
        end

        if (w_pop) begin
            w_rptr_nxt = r_rptr + ONE_P_C;
            w_remain   = r_fill - ONE_F_C;
        end else begin
            w_rptr_nxt = r_rptr;
            w_remain   = r_fill;
        end

        if (w_push) begin
            w_wptr_nxt = r_wptr + ONE_P_C;
        end else begin
            w_wptr_nxt = r_wptr;
        end

        // When nothing older survives the pop, the new head is the entry
        // being written this cycle, which is not yet in the memory array.
        if (w_fill_nxt == {(ADDR_W + 1){1'b0}}) begin
            w_data_nxt = {EW{1'b0}};
        end else if (w_remain == {(ADDR_W + 1){1'b0}}) begin
            w_data_nxt = w_entry;
        end else begin
            w_data_nxt = r_mem[w_rptr_nxt];
        end
    end

    // FIFO storage, pointers, fill level and registered head entry
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {EW{1'b0}};
            end
            r_wptr  <= {ADDR_W{1'b0}};
            r_rptr  <= {ADDR_W{1'b0}};
            r_fill  <= {(ADDR_W + 1){1'b0}};
            r_data  <= {EW{1'b0}};
            r_valid <= 1'b0;
        end else if (CLR) begin
            r_wptr  <= {ADDR_W{1'b0}};
            r_rptr  <= {ADDR_W{1'b0}};
            r_fill  <= {(ADDR_W + 1){1'b0}};
            r_data  <= {EW{1'b0}};
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
            end
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_fill  <= w_fill_nxt;
            r_data  <= w_data_nxt;
            r_valid <= (w_fill_nxt != {(ADDR_W + 1){1'b0}});
        end
    end

    // Sticky flags, saturating wrap counter and counter 2 history
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_ovf        <= 1'b0;
            r_step_err   <= 1'b0;
            r_wrap_cnt   <= 8'd0;
            r_prev2      <= {WIDTH{1'b0}};
            r_prev_valid <= 1'b0;
        end else if (CLR) begin
            r_ovf        <= 1'b0;
            r_step_err   <= 1'b0;
            r_wrap_cnt   <= 8'd0;
            r_prev2      <= CNTR_IN2;
            r_prev_valid <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_step_bad) begin
                r_step_err <= 1'b1;
            end
            if (w_wrap && (r_wrap_cnt != 8'hFF)) begin
                r_wrap_cnt <= r_wrap_cnt + 8'd1;
            end
            r_prev2      <= CNTR_IN2;
            r_prev_valid <= 1'b1;
        end
    end

    assign SNAP_DATA  = r_data;
    assign SNAP_VALID = r_valid;
    assign FILL       = r_fill;
    assign OVERFLOW   = r_ovf;
    assign STEP_ERR   = r_step_err;
    assign WRAP_CNT   = r_wrap_cnt;

endmodule
